// File: rtl/load_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_writeback_unit
// Description : Multi-cycle load path. Accepts one load request, issues a
//               word-aligned bus read, extracts and extends the returned
//               byte/half/word, and presents a single-cycle register write.
//               Misaligned/illegal loads and bus timeouts are reported.
// Revision    : 1.0 - initial release
// ============================================================================
module load_writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd_address,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_funct3,
    output logic        bus_read_enable,
    output logic [31:0] bus_address,
    input  logic        bus_ack,
    input  logic [31:0] bus_read_data,
    output logic        write_enable,
    output logic [4:0]  rd_address,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [2:0]  c_f3_lb  = 3'd0;
    localparam logic [2:0]  c_f3_lh  = 3'd1;
    localparam logic [2:0]  c_f3_lw  = 3'd2;
    localparam logic [2:0]  c_f3_lbu = 3'd4;
    localparam logic [2:0]  c_f3_lhu = 3'd5;
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WB    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_rd;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [15:0] r_count;
    logic [31:0] r_data;
    logic        r_fault_misaligned;

    logic        w_req_legal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;

    // Legality of the incoming request: alignment per access size, known funct3
    always_comb begin
        w_req_legal = 1'b0;
        case (req_funct3)
            c_f3_lb, c_f3_lbu: w_req_legal = 1'b1;
            c_f3_lh, c_f3_lhu: w_req_legal = (req_address[0] == 1'b0);
            c_f3_lw:           w_req_legal = (req_address[1:0] == 2'b00);
            default:           w_req_legal = 1'b0;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned bus word
    always_comb begin
        w_byte       = bus_read_data[{r_addr[1:0], 3'b000} +: 8];
        w_half       = bus_read_data[{r_addr[1], 4'b0000} +: 16];
        w_load_value = bus_read_data;
        case (r_funct3)
            c_f3_lb:  w_load_value = {{24{w_byte[7]}}, w_byte};
            c_f3_lh:  w_load_value = {{16{w_half[15]}}, w_half};
            c_f3_lbu: w_load_value = {24'd0, w_byte};
            c_f3_lhu: w_load_value = {16'd0, w_half};
            default:  w_load_value = bus_read_data;
        endcase
    end

    // State register plus request capture, timeout counter and data latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_rd               <= 5'd0;
            r_addr             <= 32'd0;
            r_funct3           <= 3'd0;
            r_count            <= 16'd0;
            r_data             <= 32'd0;
            r_fault_misaligned <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rd               <= req_rd_address;
                        r_addr             <= req_address;
                        r_funct3           <= req_funct3;
                        r_count            <= 16'd0;
                        r_fault_misaligned <= ~w_req_legal;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_data <= w_load_value;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        w_next_state    = r_state;
        req_ready       = 1'b0;
        busy            = 1'b1;
        bus_read_enable = 1'b0;
        bus_address     = 32'd0;
        write_enable    = 1'b0;
        rd_address      = 5'd0;
        rd_data         = 32'd0;
        misaligned      = 1'b0;
        bus_error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next_state = w_req_legal ? S_REQ : S_FAULT;
                end
            end
            S_REQ: begin
                bus_read_enable = 1'b1;
                bus_address     = {r_addr[31:2], 2'b00};
                // An ack on the final timeout cycle still completes normally
                if (bus_ack) begin
                    w_next_state = S_WB;
                end else if (r_count == c_timeout_last) begin
                    w_next_state = S_FAULT;
                end
            end
            S_WB: begin
                // x0 is never written even though the bus read took place
                if (r_rd != 5'd0) begin
                    write_enable = 1'b1;
                    rd_address   = r_rd;
                    rd_data      = r_data;
                end
                w_next_state = S_IDLE;
            end
            S_FAULT: begin
                misaligned   = r_fault_misaligned;
                bus_error    = ~r_fault_misaligned;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Multi-cycle load path that feeds the register file write port (write_enable / rd_address / rd_data).
- Accepts one load request at a time and issues a word-aligned read on the data bus.
- Waits a variable number of cycles for the acknowledge, then byte/half/word-extracts and sign- or zero-extends the data.
- Presents a single-cycle register write. Misaligned or illegal loads and bus timeouts are reported instead of written.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles REQ waits for bus_ack before aborting (1..65535).

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_rd_address  in  5  destination register.
- req_address  in  32  byte address of the load.
- req_funct3  in  3  RV32I load funct3: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- bus_read_enable  out  1  read strobe, held until ack.
- bus_address  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_ack  in  1  read data valid this cycle.
- bus_read_data  in  32  read data, sampled when bus_ack=1.
- write_enable  out  1  register write pulse.
- rd_address  out  5  register index to write.
- rd_data  out  32  extended load value.
- busy  out  1  high in every state except IDLE.
- misaligned  out  1  one-cycle pulse: misaligned or illegal funct3.
- bus_error  out  1  one-cycle pulse: bus timeout.

Behaviour:
- States: IDLE, REQ, WB, FAULT.
- Reset (asynchronous, any state): state=IDLE. All outputs 0 except req_ready=1. Internal latches and timeout counter cleared.
  - Reset mid-REQ drops bus_read_enable immediately; no register write occurs.
- IDLE:
  - req_ready=1.
  - On req_valid, capture rd, address and funct3.
  - Check: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {3,6,7} -> FAULT. Otherwise -> REQ and clear the counter.
- REQ:
  - bus_read_enable=1 and bus_address stable for the whole state.
  - bus_ack=1 -> latch extracted data, go to WB.
  - Otherwise the counter increments. At counter==TIMEOUT_CYCLES-1 with no ack -> FAULT with bus_error.
  - An ack arriving on the timeout cycle wins (normal completion).
- WB (one cycle):
  - rd_address and rd_data driven.
  - write_enable=1 only if rd!=0. For rd=0 the bus access still occurs, but write_enable stays 0.
  - -> IDLE.
- FAULT (one cycle): exactly one of misaligned or bus_error is 1. No write. -> IDLE.
- write_enable, misaligned and bus_error are 0 in every state other than the one named above.
- rd_address and rd_data are 0 whenever write_enable=0.
- Extraction, with lane = addr[1:0]:
  - byte = data[8*lane +: 8].
  - half = data[16*addr[1] +: 16].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
- Latency: request accepted at cycle N -> bus_read_enable from N+1 -> ack at N+1+k (k>=0) -> write_enable at N+2+k.
  - Minimum 2 cycles from acceptance to write.
  - Next request can be accepted at N+3+k.
- Ignored inputs:
  - bus_ack outside REQ.
  - req_valid outside IDLE; a new request is not captured.
  - Request fields changing after acceptance.
- No pipelining: at most one outstanding bus read.

Test Plan:
1. LW at 0x100, rd=5, bus returns 0xDEADBEEF with ack 3 cycles after the strobe rises -> bus_address=0x100 throughout REQ; write_enable exactly one cycle, rd_address=5, rd_data=0xDEADBEEF, at acceptance+5.
2. LB / LBU at 0x203, rd=7, data 0x80FF1234 -> LB gives rd_data=0xFFFFFF80; LBU gives 0x00000080; bus_address=0x200.
3. LH at 0x102 and LHU at 0x102, data 0x8001ABCD -> 0xFFFF8001 and 0x00008001. LH at 0x101 -> misaligned pulse one cycle, no bus_read_enable, no write.
4. LW rd=0, ack immediately -> bus strobe for one cycle, write_enable stays 0; then funct3=3 -> misaligned pulse, no bus access.
5. TIMEOUT_CYCLES=4, no ack -> bus_read_enable high exactly 4 cycles, then a bus_error pulse, no write; req_ready=1 the following cycle.
6. Assert reset asynchronously mid-REQ -> outputs clear without a clock edge. After release, a new LW completes normally and no write from the aborted load is ever seen.
